// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU constants: divider FSM encoding and counter sizing
//
// Purpose: definitions shared by the 4-bit CPU ALU blocks.
// Ports:   none (package).

package cpu_pkg;

  // Divider control FSM encoding.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Iteration counter width for an N-bit divider. It must hold the value N itself.
  function automatic int div_cnt_bits(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/carry_ripple_adder.sv
// rtl/carry_ripple_adder.sv - parameterised ripple-carry adder
//
// Purpose: sum_o = a_i + b_i + carry_i, with the carry out of the top bit on carry_o.
// Ports:
//   a_i, b_i  in   CRA_BIT_NUMB  addends
//   carry_i   in   1             carry into bit 0
//   sum_o     out  CRA_BIT_NUMB  sum
//   carry_o   out  1             carry out of the MSB

module carry_ripple_adder #(
  parameter int CRA_BIT_NUMB = 5
) (
  input  logic [CRA_BIT_NUMB-1:0] a_i,
  input  logic [CRA_BIT_NUMB-1:0] b_i,
  input  logic                    carry_i,
  output logic [CRA_BIT_NUMB-1:0] sum_o,
  output logic                    carry_o
);

  logic c;

  always_comb begin
    sum_o = '0;
    c     = carry_i;
    for (int i = 0; i < CRA_BIT_NUMB; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    carry_o = c;
  end

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
//
// Purpose: computes quotient/remainder by repeated trial subtraction on a
// carry_ripple_adder. A zero divisor returns all-ones quotient and the dividend as remainder.
// Ports:
//   clk_i          in   1  clock, rising edge
//   rst_i          in   1  asynchronous active-high reset
//   start_i        in   1  operation request; taken only while ready_o=1
//   dividend_i     in   N  unsigned dividend, sampled on accept
//   divisor_i      in   N  unsigned divisor, sampled on accept
//   ready_o        out  1  high in IDLE and DONE
//   valid_o        out  1  one-cycle result strobe
//   quotient_o     out  N  quotient, held until replaced
//   remainder_o    out  N  remainder, held until replaced
//   div_by_zero_o  out  1  last result was a divide by zero

module restoring_divider
  import cpu_pkg::*;
#(
  parameter int DIV_BIT_NUMB = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [DIV_BIT_NUMB-1:0] dividend_i,
  input  logic [DIV_BIT_NUMB-1:0] divisor_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [DIV_BIT_NUMB-1:0] quotient_o,
  output logic [DIV_BIT_NUMB-1:0] remainder_o,
  output logic                    div_by_zero_o
);

  localparam int N     = DIV_BIT_NUMB;
  localparam int CNT_W = div_cnt_bits(N);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     rem_q, quo_q, divisor_q;
  logic [N-1:0]     rem_next, quo_next;
  logic [N:0]       add_a, add_b, trial;
  logic             no_borrow;
  logic             accept;
  logic             trial_msb_unused;

  // Trial subtraction a - divisor as a + ~divisor + 1; carry out means no borrow.
  assign add_a = {rem_q, quo_q[N-1]};
  assign add_b = ~{1'b0, divisor_q};

  carry_ripple_adder #(
    .CRA_BIT_NUMB(N + 1)
  ) u_sub (
    .a_i     (add_a),
    .b_i     (add_b),
    .carry_i (1'b1),
    .sum_o   (trial),
    .carry_o (no_borrow)
  );

  // When the subtraction succeeds the difference is below the divisor, so its MSB is always zero.
  assign trial_msb_unused = trial[N];

  assign rem_next = no_borrow ? trial[N-1:0] : add_a[N-1:0];
  assign quo_next = {quo_q[N-2:0], no_borrow};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= DIV_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    accept  = 1'b0;
    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        ready_o = 1'b1;
        valid_o = (state_q == DIV_DONE);
        state_d = DIV_IDLE;
        if (start_i) begin
          accept  = 1'b1;
          state_d = (divisor_i == '0) ? DIV_DONE : DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (cnt_q == CNT_ONE) state_d = DIV_DONE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      divisor_q     <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else if (accept) begin
      divisor_q <= divisor_i;
      quo_q     <= dividend_i;
      rem_q     <= '0;
      if (divisor_i == '0) begin
        // Zero divisor skips RUN, so the result is published on the accept edge.
        cnt_q         <= '0;
        quotient_o    <= '1;
        remainder_o   <= dividend_i;
        div_by_zero_o <= 1'b1;
      end else begin
        cnt_q <= CNT_LOAD;
      end
    end else if (state_q == DIV_RUN) begin
      cnt_q <= cnt_q - CNT_ONE;
      rem_q <= rem_next;
      quo_q <= quo_next;
      if (cnt_q == CNT_ONE) begin
        quotient_o    <= quo_next;
        remainder_o   <= rem_next;
        div_by_zero_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - self-checking bench for restoring_divider

module tb_restoring_divider;

  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [N-1:0] dividend_i = '0;
  logic [N-1:0] divisor_i = '0;
  logic         ready_o, valid_o, div_by_zero_o;
  logic [N-1:0] quotient_o, remainder_o;

  restoring_divider #(.DIV_BIT_NUMB(N)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // cyc holds the number of rising edges seen; the period after edge j has cyc==j.
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           vcyc;
  } exp_t;

  typedef struct {
    logic [N-1:0] dd;
    logic [N-1:0] dv;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } vec_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor: every valid_o pulse must match the oldest outstanding operation.
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient_o, e.q);
        check("remainder", remainder_o, e.r);
        check("div_by_zero", div_by_zero_o, e.dbz);
        check("latency", cyc, e.vcyc);
      end
    end
  end

  // Waits for ready_o, issues one op, records its expected result and valid_o cycle.
  // hold>0 keeps start_i high for that many further edges (the RUN phase).
  task automatic do_op(input logic [N-1:0] dd, input logic [N-1:0] dv,
                       input logic [N-1:0] q, input logic [N-1:0] r,
                       input logic dbz, input int hold);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk_i);
    while (!ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      check("ready_timeout", ready_o, 1);
    end else begin
      start_i    = 1'b1;
      dividend_i = dd;
      divisor_i  = dv;
      @(posedge clk_i);
      #1;
      e.q    = q;
      e.r    = r;
      e.dbz  = dbz;
      // Accept at edge k: valid_o in the period after edge k (zero divisor) or k+N.
      e.vcyc = cyc + (dbz ? 0 : N);
      sb.push_back(e);
      repeat (hold) begin
        @(posedge clk_i);
        #1;
      end
      start_i = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[10];
    logic [N-1:0] eq, er;

    tbl[0] = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0};
    tbl[1] = '{4'd7,  4'd0,  4'd15, 4'd7,  1'b1};
    tbl[2] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
    tbl[3] = '{4'd2,  4'd9,  4'd0,  4'd2,  1'b0};
    tbl[4] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
    tbl[5] = '{4'd0,  4'd7,  4'd0,  4'd0,  1'b0};
    tbl[6] = '{4'd15, 4'd0,  4'd15, 4'd15, 1'b1};
    tbl[7] = '{4'd0,  4'd0,  4'd15, 4'd0,  1'b1};
    tbl[8] = '{4'd1,  4'd1,  4'd1,  4'd0,  1'b0};
    tbl[9] = '{4'd14, 4'd2,  4'd7,  4'd0,  1'b0};

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_quotient", quotient_o, 0);
    check("rst_remainder", remainder_o, 0);
    check("rst_dbz", div_by_zero_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // 13/3 with ready_o low for the N RUN cycles
    do_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 0);
    repeat (N) begin
      @(negedge clk_i);
      check("run_ready_low", ready_o, 0);
    end
    drain();

    // Table vectors, issued back-to-back (including consecutive zero divisors)
    for (int i = 0; i < 10; i++)
      do_op(tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r, tbl[i].dbz, 0);
    drain();

    // start_i held high through RUN must not start another op
    do_op(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, N - 1);
    drain();
    repeat (5) begin
      @(negedge clk_i);
      check("idle_hold_q", quotient_o, 2);
      check("idle_hold_r", remainder_o, 2);
    end

    // Exhaustive sweep against an arithmetic model
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        if (dv == 0) begin
          eq = 4'hF;
          er = N'(dd);
        end else begin
          eq = N'(dd / dv);
          er = N'(dd % dv);
        end
        do_op(N'(dd), N'(dv), eq, er, dv == 0, 0);
      end
    end
    drain();

    // Asynchronous reset in the middle of a 11/2 run
    do_op(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 0);
    sb.delete();
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("async_rst_ready", ready_o, 1);
    check("async_rst_valid", valid_o, 0);
    check("async_rst_quotient", quotient_o, 0);
    check("async_rst_remainder", remainder_o, 0);
    check("async_rst_dbz", div_by_zero_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      check("post_rst_no_valid", valid_o, 0);
    end
    do_op(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
